// File: rtl/yuv444_to_yuv422_pkg.sv
// +-----------------------------------------------------------------------------
// | yuv444_to_yuv422_pkg : token type codes, pixel test macro and chroma select
// | codes shared by the 4:4:4 -> 4:2:2 subsampler. Revision 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 3
`endif

`define IS_PIXEL(t) ((t) == yuv444_to_yuv422_pkg::DTYPE_PIXEL)

package yuv444_to_yuv422_pkg;

   localparam logic [`DTYPE_WIDTH-1:0] DTYPE_PIXEL       = `DTYPE_WIDTH'(0);
   localparam logic [`DTYPE_WIDTH-1:0] DTYPE_FRAME_START = `DTYPE_WIDTH'(1);
   localparam logic [`DTYPE_WIDTH-1:0] DTYPE_ROW_START   = `DTYPE_WIDTH'(2);
   localparam logic [`DTYPE_WIDTH-1:0] DTYPE_ROW_END     = `DTYPE_WIDTH'(3);
   localparam logic [`DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = `DTYPE_WIDTH'(4);

   localparam logic CSEL_U = 1'b0;
   localparam logic CSEL_V = 1'b1;

endpackage

`default_nettype wire

// File: rtl/chroma_pair_avg.sv
// +-----------------------------------------------------------------------------
// | chroma_pair_avg : rounded average of two chroma samples when
// | YUV422_AVERAGE_EN is defined, otherwise passes sample a through.
// | Revision 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module chroma_pair_avg #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] avg
);

`ifdef YUV422_AVERAGE_EN
   // One extra bit holds the carry; dropping the LSB is the divide by two.
   logic w_unused_lsb;
   assign {avg, w_unused_lsb} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(1);
`else
   logic w_unused_b;
   assign w_unused_b = ^b;
   assign avg        = a;
`endif

endmodule

`default_nettype wire

// File: rtl/yuv444_to_yuv422.sv
// +-----------------------------------------------------------------------------
// | yuv444_to_yuv422 : one-token holding stage that pairs even/odd pixels and
// | emits 4:2:2 (U on even, V on odd). Averaging enabled by YUV422_AVERAGE_EN.
// | Revision 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module yuv444_to_yuv422
   import yuv444_to_yuv422_pkg::*;
#(
   parameter int PIXEL_WIDTH = 10,
   parameter int META_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    dvi,
   input  logic [`DTYPE_WIDTH-1:0] dtypei,
   input  logic [PIXEL_WIDTH-1:0]  yi,
   input  logic [PIXEL_WIDTH-1:0]  ui,
   input  logic [PIXEL_WIDTH-1:0]  vi,
   input  logic [META_WIDTH-1:0]   meta_datai,
   output logic                    dvo,
   output logic [`DTYPE_WIDTH-1:0] dtypeo,
   output logic [PIXEL_WIDTH-1:0]  yo,
   output logic [PIXEL_WIDTH-1:0]  co,
   output logic                    csel,
   output logic [META_WIDTH-1:0]   meta_datao
);

   logic                    r_h_valid;
   logic                    r_h_odd;
   logic                    r_parity;
   logic [`DTYPE_WIDTH-1:0] r_h_dtype;
   logic [PIXEL_WIDTH-1:0]  r_h_y;
   logic [PIXEL_WIDTH-1:0]  r_h_u;
   logic [PIXEL_WIDTH-1:0]  r_h_v;
   logic [META_WIDTH-1:0]   r_h_meta;

   logic                    w_in_pix;
   logic                    w_in_odd;
   logic                    w_h_pix;
   logic                    w_h_even;
   logic                    w_emit;
   logic [PIXEL_WIDTH-1:0]  w_avg_u;
   logic [PIXEL_WIDTH-1:0]  w_avg_v;
   logic [PIXEL_WIDTH-1:0]  w_co;
   logic                    w_csel;

   // U pairs held-even with incoming-odd; V is computed when the odd arrives.
   chroma_pair_avg #(.WIDTH(PIXEL_WIDTH)) u_avg_u (
      .a   (r_h_u),
      .b   (ui),
      .avg (w_avg_u)
   );

   chroma_pair_avg #(.WIDTH(PIXEL_WIDTH)) u_avg_v (
      .a   (vi),
      .b   (r_h_v),
      .avg (w_avg_v)
   );

   assign w_in_pix = `IS_PIXEL(dtypei);
   assign w_in_odd = w_in_pix && r_parity;
   assign w_h_pix  = `IS_PIXEL(r_h_dtype);
   assign w_h_even = r_h_valid && w_h_pix && !r_h_odd;
   assign w_emit   = r_h_valid && (dvi || !w_h_even);

   always_comb begin
      w_co   = r_h_u;
      w_csel = CSEL_U;
      if (w_h_even) begin
         if (w_in_pix) begin
            w_co = w_avg_u;
         end
      end else if (w_h_pix) begin
         w_co   = r_h_v;
         w_csel = CSEL_V;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_h_valid  <= 1'b0;
         r_h_odd    <= 1'b0;
         r_parity   <= 1'b0;
         r_h_dtype  <= '0;
         r_h_y      <= '0;
         r_h_u      <= '0;
         r_h_v      <= '0;
         r_h_meta   <= '0;
         dvo        <= 1'b0;
         dtypeo     <= '0;
         yo         <= '0;
         co         <= '0;
         csel       <= 1'b0;
         meta_datao <= '0;
      end else begin
         dvo <= w_emit;
         if (w_emit) begin
            dtypeo     <= r_h_dtype;
            yo         <= r_h_y;
            co         <= w_co;
            csel       <= w_csel;
            meta_datao <= r_h_meta;
         end
         if (dvi) begin
            r_h_valid <= 1'b1;
            r_h_dtype <= dtypei;
            r_h_y     <= yi;
            r_h_u     <= ui;
            r_h_meta  <= meta_datai;
            r_h_odd   <= w_in_odd;
            r_h_v     <= w_in_odd ? w_avg_v : vi;
            r_parity  <= w_in_pix && !r_parity;
         end else if (w_emit) begin
            r_h_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_yuv444_to_yuv422.sv
// +-----------------------------------------------------------------------------
// | tb_yuv444_to_yuv422 : directed vector table plus reset sequence for the
// | 4:2:2 subsampler; expectations follow YUV422_AVERAGE_EN. Revision 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

`ifdef YUV422_AVERAGE_EN
`define TB_PICK(avg_val, cos_val) (avg_val)
`else
`define TB_PICK(avg_val, cos_val) (cos_val)
`endif

module tb_yuv444_to_yuv422;
   import yuv444_to_yuv422_pkg::*;

   localparam int PW = 10;
   localparam int MW = 16;
   localparam int DW = `DTYPE_WIDTH;

   typedef struct {
      logic          dv;
      logic [DW-1:0] dt;
      logic [PW-1:0] y;
      logic [PW-1:0] u;
      logic [PW-1:0] v;
      logic [MW-1:0] meta;
      logic          edv;
      logic [DW-1:0] edt;
      logic [PW-1:0] ey;
      logic [PW-1:0] eco;
      logic          ecs;
      logic [MW-1:0] emeta;
   } vec_t;

   logic          clk;
   logic          reset;
   logic          dvi;
   logic [DW-1:0] dtypei;
   logic [PW-1:0] yi, ui, vi;
   logic [MW-1:0] meta_datai;
   logic          dvo;
   logic [DW-1:0] dtypeo;
   logic [PW-1:0] yo, co;
   logic          csel;
   logic [MW-1:0] meta_datao;

   int n_checks = 0;
   int n_errors = 0;
   vec_t vq[$];

   yuv444_to_yuv422 #(.PIXEL_WIDTH(PW), .META_WIDTH(MW)) dut (
      .clk        (clk),
      .reset      (reset),
      .dvi        (dvi),
      .dtypei     (dtypei),
      .yi         (yi),
      .ui         (ui),
      .vi         (vi),
      .meta_datai (meta_datai),
      .dvo        (dvo),
      .dtypeo     (dtypeo),
      .yo         (yo),
      .co         (co),
      .csel       (csel),
      .meta_datao (meta_datao)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic dv, input logic [DW-1:0] dt,
                               input int y, input int u, input int v, input int meta,
                               input logic edv, input logic [DW-1:0] edt,
                               input int ey, input int eco, input logic ecs, input int emeta);
      vec_t t;
      t.dv = dv;   t.dt = dt;   t.y = PW'(y);    t.u = PW'(u);     t.v = PW'(v);
      t.meta = MW'(meta);
      t.edv = edv; t.edt = edt; t.ey = PW'(ey);  t.eco = PW'(eco); t.ecs = ecs;
      t.emeta = MW'(emeta);
      return t;
   endfunction

   function automatic vec_t idle0();
      return mk(1'b0, DTYPE_PIXEL, 0, 0, 0, 0, 1'b0, DTYPE_PIXEL, 0, 0, 1'b0, 0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " dvo"},    32'(dvo),        32'd0);
      check({tag, " dtypeo"}, 32'(dtypeo),     32'd0);
      check({tag, " yo"},     32'(yo),         32'd0);
      check({tag, " co"},     32'(co),         32'd0);
      check({tag, " csel"},   32'(csel),       32'd0);
      check({tag, " meta"},   32'(meta_datao), 32'd0);
   endtask

   task automatic step(input vec_t t, input int idx);
      string tag;
      @(negedge clk);
      dvi = t.dv; dtypei = t.dt; yi = t.y; ui = t.u; vi = t.v; meta_datai = t.meta;
      @(posedge clk);
      #1;
      tag = $sformatf("v%0d", idx);
      check({tag, " dvo"}, 32'(dvo), 32'(t.edv));
      if (t.edv) begin
         check({tag, " dtypeo"}, 32'(dtypeo),     32'(t.edt));
         check({tag, " yo"},     32'(yo),         32'(t.ey));
         check({tag, " co"},     32'(co),         32'(t.eco));
         check({tag, " csel"},   32'(csel),       32'(t.ecs));
         check({tag, " meta"},   32'(meta_datao), 32'(t.emeta));
      end
   endtask

   initial begin
      reset = 1'b1; dvi = 1'b0; dtypei = '0; yi = '0; ui = '0; vi = '0; meta_datai = '0;

      // Row of 4 inside a frame, meta tagged 0xA000+index on 8 tokens
      vq.push_back(mk(1, DTYPE_FRAME_START, 0, 0, 0, 'hA000, 0, DTYPE_PIXEL, 0, 0, 0, 0));
      vq.push_back(mk(1, DTYPE_ROW_START, 0, 0, 0, 'hA001, 1, DTYPE_FRAME_START, 0, 0, 0, 'hA000));
      vq.push_back(mk(1, DTYPE_PIXEL, 1, 100, 50, 'hA002, 1, DTYPE_ROW_START, 0, 0, 0, 'hA001));
      vq.push_back(mk(1, DTYPE_PIXEL, 2, 102, 51, 'hA003, 1, DTYPE_PIXEL, 1, `TB_PICK(101, 100), 0, 'hA002));
      vq.push_back(mk(1, DTYPE_PIXEL, 3, 200, 60, 'hA004, 1, DTYPE_PIXEL, 2, `TB_PICK(51, 51), 1, 'hA003));
      vq.push_back(mk(1, DTYPE_PIXEL, 4, 201, 63, 'hA005, 1, DTYPE_PIXEL, 3, `TB_PICK(201, 200), 0, 'hA004));
      vq.push_back(mk(1, DTYPE_ROW_END, 0, 0, 0, 'hA006, 1, DTYPE_PIXEL, 4, `TB_PICK(62, 63), 1, 'hA005));
      vq.push_back(mk(1, DTYPE_FRAME_END, 0, 0, 0, 'hA007, 1, DTYPE_ROW_END, 0, 0, 0, 'hA006));
      vq.push_back(mk(0, DTYPE_PIXEL, 0, 0, 0, 0, 1, DTYPE_FRAME_END, 0, 0, 0, 'hA007));
      vq.push_back(idle0());
      // Odd-width row: third pixel flushed unpaired by ROW_END
      vq.push_back(mk(1, DTYPE_ROW_START, 0, 0, 0, 'hA010, 0, DTYPE_PIXEL, 0, 0, 0, 0));
      vq.push_back(mk(1, DTYPE_PIXEL, 1, 10, 20, 'hA011, 1, DTYPE_ROW_START, 0, 0, 0, 'hA010));
      vq.push_back(mk(1, DTYPE_PIXEL, 2, 30, 40, 'hA012, 1, DTYPE_PIXEL, 1, `TB_PICK(20, 10), 0, 'hA011));
      vq.push_back(mk(1, DTYPE_PIXEL, 3, 300, 5, 'hA013, 1, DTYPE_PIXEL, 2, `TB_PICK(30, 40), 1, 'hA012));
      vq.push_back(mk(1, DTYPE_ROW_END, 9, 7, 8, 'hA014, 1, DTYPE_PIXEL, 3, 300, 0, 'hA013));
      vq.push_back(mk(0, DTYPE_PIXEL, 0, 0, 0, 0, 1, DTYPE_ROW_END, 9, 7, 0, 'hA014));
      vq.push_back(idle0());
      // Gapped pair: even held silently through the gap
      vq.push_back(mk(1, DTYPE_ROW_START, 0, 0, 0, 'hA020, 0, DTYPE_PIXEL, 0, 0, 0, 0));
      vq.push_back(mk(1, DTYPE_PIXEL, 5, 40, 60, 'hA021, 1, DTYPE_ROW_START, 0, 0, 0, 'hA020));
      for (int i = 0; i < 5; i++) vq.push_back(idle0());
      vq.push_back(mk(1, DTYPE_PIXEL, 6, 42, 62, 'hA022, 1, DTYPE_PIXEL, 5, `TB_PICK(41, 40), 0, 'hA021));
      vq.push_back(mk(0, DTYPE_PIXEL, 0, 0, 0, 0, 1, DTYPE_PIXEL, 6, `TB_PICK(61, 62), 1, 'hA022));
      vq.push_back(idle0());
      vq.push_back(mk(1, DTYPE_ROW_END, 0, 0, 0, 'hA023, 0, DTYPE_PIXEL, 0, 0, 0, 0));
      vq.push_back(mk(0, DTYPE_PIXEL, 0, 0, 0, 0, 1, DTYPE_ROW_END, 0, 0, 0, 'hA023));
      // Full-scale chroma, no wrap
      vq.push_back(mk(1, DTYPE_ROW_START, 0, 0, 0, 'hA030, 0, DTYPE_PIXEL, 0, 0, 0, 0));
      vq.push_back(mk(1, DTYPE_PIXEL, 10, 1023, 1022, 'hA031, 1, DTYPE_ROW_START, 0, 0, 0, 'hA030));
      vq.push_back(mk(1, DTYPE_PIXEL, 11, 1023, 1023, 'hA032, 1, DTYPE_PIXEL, 10, 1023, 0, 'hA031));
      vq.push_back(mk(1, DTYPE_FRAME_END, 0, 0, 0, 'hA033, 1, DTYPE_PIXEL, 11, 1023, 1, 'hA032));
      vq.push_back(mk(0, DTYPE_PIXEL, 0, 0, 0, 0, 1, DTYPE_FRAME_END, 0, 0, 0, 'hA033));
      vq.push_back(idle0());

      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      foreach (vq[i]) step(vq[i], i);

      // Reset while an even pixel is held: it must never come out
      step(mk(1, DTYPE_ROW_START, 33, 44, 55, 'hBEEF, 0, DTYPE_PIXEL, 0, 0, 0, 0), 100);
      step(mk(1, DTYPE_PIXEL, 7, 11, 12, 'hB001, 1, DTYPE_ROW_START, 33, 44, 0, 'hBEEF), 101);
      @(negedge clk);
      dvi = 1'b0;
      reset = 1'b1;
      #1;
      check_outputs_zero("async rst");
      @(posedge clk);
      #1;
      check_outputs_zero("held rst");
      @(negedge clk);
      reset = 1'b0;
      step(idle0(), 102);
      step(mk(1, DTYPE_ROW_START, 0, 0, 0, 'hB002, 0, DTYPE_PIXEL, 0, 0, 0, 0), 103);
      step(mk(1, DTYPE_PIXEL, 8, 13, 14, 'hB003, 1, DTYPE_ROW_START, 0, 0, 0, 'hB002), 104);
      step(mk(1, DTYPE_PIXEL, 9, 15, 16, 'hB004, 1, DTYPE_PIXEL, 8, `TB_PICK(14, 13), 0, 'hB003), 105);
      step(mk(1, DTYPE_ROW_END, 0, 0, 0, 'hB005, 1, DTYPE_PIXEL, 9, `TB_PICK(15, 16), 1, 'hB004), 106);
      step(mk(0, DTYPE_PIXEL, 0, 0, 0, 0, 1, DTYPE_ROW_END, 0, 0, 0, 'hB005), 107);
      step(idle0(), 108);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`undef TB_PICK

`default_nettype wire
